// File: rtl/seven_seg_pkg.sv
// Shared types and the hex segment table for the 7-segment capture block.
// Segment patterns are active-high, bit order gfedcba.
package seven_seg_pkg;

   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD, ERR} cap_state_t;

   typedef enum logic [1:0] {AN_NONE, AN_ONE, AN_MULTI} anode_class_t;

   typedef struct packed {
      logic       hit;
      logic       blank;
      logic [3:0] nibble;
   } seg_dec_t;

   // nibble stays 0 for blank and unknown patterns, so callers can store it unconditionally
   function automatic seg_dec_t seg_decode(input logic [6:0] segs);
      seg_dec_t r;
      r       = '0;
      r.blank = (segs == 7'h00);
      for (int i = 0; i < 16; i++) begin
         if (segs == SEG_HEX[i]) begin
            r.hit    = 1'b1;
            r.nibble = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational decode of one active-low cathode byte into hex nibble,
// blank/hit flags and the digit point.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [7:0] cathode,
   output logic       hit,
   output logic       blank,
   output logic [3:0] nibble,
   output logic       dp
);

   seg_dec_t dec;

   assign dec    = seg_decode(~cathode[6:0]);
   assign hit    = dec.hit;
   assign blank  = dec.blank;
   assign nibble = dec.nibble;
   assign dp     = ~cathode[7];

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed 7-segment interface: waits for stable anode/cathode,
// decodes each digit and pulses frame_valid once all digits were seen. Optional input
// synchronizers are enabled by defining SEVSEG_CAP_SYNC_EN.
module seven_segment_capture
   import seven_seg_pkg::*;
#(
   parameter int NUM_SEGMENTS  = 4,
   parameter int SETTLE_CYCLES = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_SEGMENTS-1:0]      anode,
   input  logic [7:0]                   cathode,
   output logic [NUM_SEGMENTS-1:0][3:0] encoded,
   output logic [NUM_SEGMENTS-1:0]      digit_point,
   output logic [NUM_SEGMENTS-1:0]      digit_blank,
   output logic [NUM_SEGMENTS-1:0]      decode_err,
   output logic                         frame_valid,
   output logic                         anode_err
);

   localparam int IDX_W = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   logic [NUM_SEGMENTS-1:0] anode_s;
   logic [7:0]              cathode_s;

`ifdef SEVSEG_CAP_SYNC_EN
   logic [NUM_SEGMENTS-1:0] anode_m;
   logic [7:0]              cathode_m;

   // Reset to all ones so the synchronizers present an idle bus
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode_m   <= '1;
         anode_s   <= '1;
         cathode_m <= '1;
         cathode_s <= '1;
      end else begin
         anode_m   <= anode;
         anode_s   <= anode_m;
         cathode_m <= cathode;
         cathode_s <= cathode_m;
      end
   end
`else
   assign anode_s   = anode;
   assign cathode_s = cathode;
`endif

   anode_class_t   an_class;
   logic [IDX_W-1:0] an_idx;

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      an_class = AN_NONE;
      an_idx   = '0;
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
         if (!anode_s[i]) begin
            an_class = (an_class == AN_NONE) ? AN_ONE : AN_MULTI;
            an_idx   = IDX_W'(i);
         end
      end
   end

   logic       dec_hit, dec_blank, dec_dp;
   logic [3:0] dec_nibble;

   seven_seg_decode u_decode (
      .cathode (cathode_s),
      .hit     (dec_hit),
      .blank   (dec_blank),
      .nibble  (dec_nibble),
      .dp      (dec_dp)
   );

   cap_state_t              state;
   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        lat_idx;
   logic [7:0]              lat_cathode;
   logic [NUM_SEGMENTS-1:0] seen, seen_set;
   logic                    same, start_settle, do_sample;

   assign same         = (an_idx == lat_idx) && (cathode_s == lat_cathode);
   assign start_settle = (an_class == AN_ONE) && (state == IDLE || state == ERR || !same);
   // Sample on the SETTLE_CYCLES-th consecutive cycle the digit has been stable
   assign do_sample    = (an_class == AN_ONE) &&
                         ((state == SETTLE && same && cnt == CNT_W'(SETTLE_CYCLES - 1)) ||
                          (start_settle && SETTLE_CYCLES == 1));
   assign seen_set     = seen | (NUM_SEGMENTS'(1) << an_idx);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         lat_idx     <= '0;
         lat_cathode <= '1;
         seen        <= '0;
         encoded     <= '0;
         digit_point <= '0;
         digit_blank <= '0;
         decode_err  <= '0;
         frame_valid <= 1'b0;
         anode_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         anode_err   <= 1'b0;

         if (an_class == AN_MULTI) begin
            if (state != ERR) anode_err <= 1'b1;
            state <= ERR;
         end else if (an_class == AN_NONE) begin
            state <= IDLE;
         end else begin
            if (start_settle) begin
               lat_idx     <= an_idx;
               lat_cathode <= cathode_s;
            end
            if (do_sample) begin
               state <= HOLD;
            end else if (start_settle) begin
               state <= SETTLE;
               cnt   <= CNT_W'(1);
            end else if (state == SETTLE) begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         if (do_sample) begin
            encoded[an_idx]     <= dec_nibble;
            digit_blank[an_idx] <= dec_blank;
            decode_err[an_idx]  <= !dec_hit && !dec_blank;
            digit_point[an_idx] <= dec_dp;
            if (&seen_set) begin
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen <= seen_set;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with hand-computed expectations.
module tb_seven_segment_capture;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       anode;
   logic [7:0]       cathode;
   logic [3:0][3:0]  encoded;
   logic [3:0]       digit_point, digit_blank, decode_err;
   logic             frame_valid, anode_err;

   int errors = 0;
   int checks = 0;
   int fv_count = 0;
   int ae_count = 0;

   always #5 clk = ~clk;

   seven_segment_capture #(.NUM_SEGMENTS(4), .SETTLE_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .anode       (anode),
      .cathode     (cathode),
      .encoded     (encoded),
      .digit_point (digit_point),
      .digit_blank (digit_blank),
      .decode_err  (decode_err),
      .frame_valid (frame_valid),
      .anode_err   (anode_err)
   );

   always @(negedge clk) begin
      if (frame_valid) fv_count++;
      if (anode_err) ae_count++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] an, input logic [7:0] ca);
      anode   = an;
      cathode = ca;
   endtask

   initial begin
      reset = 1'b1;
      drive(4'hF, 8'hFF);
      cycles(2);
      reset = 1'b0;
      cycles(1);
      check("reset_encoded", encoded, 16'h0000);
      check("reset_dp", digit_point, 4'h0);
      check("reset_blank", digit_blank, 4'h0);
      check("reset_err", decode_err, 4'h0);
      check("reset_pulses", {frame_valid, anode_err}, 2'b00);

      // 1: digit 0 shows "1"
      drive(4'b1110, ~8'h06);
      cycles(3);
      check("t1_not_yet", encoded, 16'h0000);
      cycles(1);
      check("t1_encoded", encoded, 16'h0001);
      check("t1_dp", digit_point, 4'h0);
      cycles(6);
      check("t1_no_frame", fv_count, 0);

      // 2: full scan 3, A, 7 with dp, F
      drive(4'b1110, ~8'h4F); cycles(10);
      drive(4'b1101, ~8'h77); cycles(10);
      drive(4'b1011, ~8'h87); cycles(10);
      check("t2_no_early_frame", fv_count, 0);
      drive(4'b0111, ~8'h71);
      cycles(3);
      check("t2_fv_before", frame_valid, 1'b0);
      cycles(1);
      check("t2_fv_pulse", frame_valid, 1'b1);
      check("t2_encoded", encoded, 16'hF7A3);
      cycles(1);
      check("t2_fv_single", frame_valid, 1'b0);
      cycles(5);
      check("t2_frame_count", fv_count, 1);
      check("t2_dp", digit_point, 4'b0100);
      check("t2_blank_err", {digit_blank, decode_err}, 8'h00);

      // 3: short glitch on digit 2 ignored, then blank
      drive(4'b1011, ~8'h06); cycles(3);
      drive(4'b1011, 8'hFF);
      check("t3_glitch_ignored", encoded, 16'hF7A3);
      cycles(3);
      check("t3_blank_not_yet", digit_blank, 4'h0);
      cycles(1);
      check("t3_blank", digit_blank, 4'b0100);
      check("t3_encoded", encoded, 16'hF0A3);
      check("t3_dp_cleared", digit_point, 4'h0);
      drive(4'hF, 8'hFF); cycles(3);

      // 4: illegal pattern on digit 1, then a valid "2"
      drive(4'b1101, ~8'h49); cycles(4);
      check("t4_err", decode_err, 4'b0010);
      check("t4_encoded", encoded, 16'hF003);
      drive(4'b1101, ~8'h5B); cycles(4);
      check("t4_err_cleared", decode_err, 4'h0);
      check("t4_encoded2", encoded, 16'hF023);

      // 5: two anodes low
      drive(4'b1100, ~8'h06);
      cycles(1);
      check("t5_ae_pulse", anode_err, 1'b1);
      cycles(1);
      check("t5_ae_single", anode_err, 1'b0);
      cycles(3);
      check("t5_ae_count", ae_count, 1);
      check("t5_regs_kept", {encoded, digit_blank, decode_err}, 24'hF02340);
      drive(4'b1110, ~8'h3F); cycles(10);
      drive(4'b0111, ~8'h66); cycles(10);
      check("t5_frame_count", fv_count, 2);
      check("t5_encoded", encoded, 16'h4020);
      check("t5_blank", digit_blank, 4'b0100);

      // 6: reset after two digits discards the partial frame
      drive(4'b1110, ~8'h6D); cycles(10);
      drive(4'b1101, ~8'h7D); cycles(10);
      check("t6_pre_reset", encoded, 16'h4065);
      reset = 1'b1;
      #2;
      check("t6_reset_encoded", encoded, 16'h0000);
      check("t6_reset_flags", {digit_point, digit_blank, decode_err}, 12'h000);
      drive(4'hF, 8'hFF);
      cycles(1);
      reset = 1'b0;
      cycles(1);
      drive(4'b1011, ~8'h7F); cycles(10);
      drive(4'b0111, ~8'h6F); cycles(10);
      check("t6_no_partial_frame", fv_count, 2);
      drive(4'b1110, ~8'h39); cycles(10);
      drive(4'b1101, ~8'h79); cycles(10);
      check("t6_frame_count", fv_count, 3);
      check("t6_encoded", encoded, 16'h98EC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
